// File: rtl/rvfpm_xif_queue.sv
// In-order issue queue between the X-interface issue port and the FPU pipeline.
// Entries wait for commit/kill by id; committed ones dispatch in issue order, killed ones drop.
module rvfpm_xif_queue #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                              ck,
    input  logic                              rst,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [X_ID_WIDTH-1:0]             issue_id,
    input  logic [PAYLOAD_W-1:0]              issue_payload,
    input  logic                              commit_valid,
    input  logic [X_ID_WIDTH-1:0]             commit_id,
    input  logic                              commit_kill,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [X_ID_WIDTH-1:0]             out_id,
    output logic [PAYLOAD_W-1:0]              out_payload,
    output logic [CNT_W-1:0]                  count,
    output logic [QUEUE_DEPTH*X_ID_WIDTH-1:0] dbg_ids,
    output logic [QUEUE_DEPTH-1:0]            dbg_valid
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [X_ID_WIDTH-1:0] id_q [QUEUE_DEPTH];
    logic [X_ID_WIDTH-1:0] id_d [QUEUE_DEPTH];
    logic [PAYLOAD_W-1:0]  pl_q [QUEUE_DEPTH];
    logic [PAYLOAD_W-1:0]  pl_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] cmt_q, cmt_d, kil_q, kil_d;
    ptr_t                  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic head_occ, issue_acc, pop, drop, found, bypass;
    ptr_t tgt, idx;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (32'(p) == QUEUE_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Physical slot of the entry that is `age` positions behind `base`.
    function automatic ptr_t age_idx(input ptr_t base, input int unsigned age);
        int unsigned sum;
        sum = 32'(base) + age;
        if (sum >= QUEUE_DEPTH) sum = sum - QUEUE_DEPTH;
        return ptr_t'(sum);
    endfunction

    assign head_occ    = (count_q != '0);
    assign issue_ready = rst & ~flush & (count_q < CNT_W'(QUEUE_DEPTH));
    assign out_valid   = head_occ & cmt_q[head_q] & ~kil_q[head_q];
    assign out_id      = id_q[head_q];
    assign out_payload = pl_q[head_q];
    assign count       = count_q;
    assign issue_acc   = issue_valid & issue_ready;
    assign pop         = out_valid & out_ready;
    assign drop        = head_occ & kil_q[head_q];

    // Oldest live, still-pending entry carrying commit_id.
    always_comb begin
        found = 1'b0;
        tgt   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            idx = age_idx(head_q, i);
            if (!found && (i < 32'(count_q)) && (id_q[idx] == commit_id) &&
                !cmt_q[idx] && !kil_q[idx]) begin
                found = 1'b1;
                tgt   = idx;
            end
        end
    end

    always_comb begin
        id_d    = id_q;
        pl_d    = pl_q;
        cmt_d   = cmt_q;
        kil_d   = kil_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        bypass  = 1'b0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_valid && found) begin
                if (commit_kill) kil_d[tgt] = 1'b1;
                else             cmt_d[tgt] = 1'b1;
            end
            // No stored match: the commit lands on the entry being issued this cycle.
            bypass = commit_valid & ~found & (commit_id == issue_id);
            if (issue_acc) begin
                id_d[tail_q]  = issue_id;
                pl_d[tail_q]  = issue_payload;
                cmt_d[tail_q] = bypass & ~commit_kill;
                kil_d[tail_q] = bypass & commit_kill;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop | drop) head_d = ptr_inc(head_q);
            count_d = count_q + CNT_W'(issue_acc) - CNT_W'(pop | drop);
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                id_q[i] <= '0;
                pl_q[i] <= '0;
            end
            cmt_q   <= '0;
            kil_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            id_q    <= id_d;
            pl_q    <= pl_d;
            cmt_q   <= cmt_d;
            kil_q   <= kil_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        dbg_ids   = '0;
        dbg_valid = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            dbg_ids[i*X_ID_WIDTH +: X_ID_WIDTH] = id_q[age_idx(head_q, i)];
            dbg_valid[i] = (i < 32'(count_q));
        end
    end

endmodule

// File: tb/tb_rvfpm_xif_queue.sv
// Scoreboard bench for rvfpm_xif_queue: depth-4 instance for most scenarios,
// depth-3 instance for the wrap/stall scenario.
module tb_rvfpm_xif_queue;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] pl;
    } exp_t;

    logic        ck = 1'b0;
    logic        rst, issue_valid, commit_valid, commit_kill, flush, out_ready;
    logic [3:0]  issue_id, commit_id;
    logic [63:0] issue_payload;

    logic        issue_ready_a, out_valid_a;
    logic [3:0]  out_id_a;
    logic [63:0] out_payload_a;
    logic [2:0]  count_a;
    logic [15:0] dbg_ids_a;
    logic [3:0]  dbg_valid_a;

    logic        issue_ready_b, out_valid_b;
    logic [3:0]  out_id_b;
    logic [63:0] out_payload_b;
    logic [1:0]  count_b;
    logic [11:0] dbg_ids_b;
    logic [2:0]  dbg_valid_b;

    int   n_checks, n_pass, issued, cyc;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_sel;
    logic m_valid;
    logic [3:0]  m_id, m_dbg0, prev_id;
    logic [63:0] m_pl, prev_pl;
    logic prev_stall = 1'b0;

    always #5 ck = ~ck;

    rvfpm_xif_queue u_dut_a (
        .ck(ck), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_a),
        .issue_id(issue_id), .issue_payload(issue_payload), .commit_valid(commit_valid),
        .commit_id(commit_id), .commit_kill(commit_kill), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_id(out_id_a),
        .out_payload(out_payload_a), .count(count_a), .dbg_ids(dbg_ids_a),
        .dbg_valid(dbg_valid_a)
    );

    rvfpm_xif_queue #(.QUEUE_DEPTH(3)) u_dut_b (
        .ck(ck), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready_b),
        .issue_id(issue_id), .issue_payload(issue_payload), .commit_valid(commit_valid),
        .commit_id(commit_id), .commit_kill(commit_kill), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_id(out_id_b),
        .out_payload(out_payload_b), .count(count_b), .dbg_ids(dbg_ids_b),
        .dbg_valid(dbg_valid_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic drive_issue(input logic [3:0] id, input logic expect_out);
        exp_t e;
        e.id          = id;
        e.pl          = {$urandom, $urandom};
        issue_valid   = 1'b1;
        issue_id      = id;
        issue_payload = e.pl;
        if (expect_out) exp_q.push_back(e);
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    always_comb begin
        m_valid = mon_sel ? out_valid_b       : out_valid_a;
        m_id    = mon_sel ? out_id_b          : out_id_a;
        m_pl    = mon_sel ? out_payload_b     : out_payload_a;
        m_dbg0  = mon_sel ? dbg_ids_b[3:0]    : dbg_ids_a[3:0];
    end

    // Output monitor: every pop is compared against the scoreboard head.
    always @(negedge ck) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 64'(m_valid), 64'd1);
                check_val("stall_id", 64'(m_id), 64'(prev_id));
                check_val("stall_payload", m_pl, prev_pl);
            end
            if (m_valid) check_val("dbg_head_id", 64'(m_dbg0), 64'(m_id));
            if (m_valid && out_ready) begin
                check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("pop_id", 64'(m_id), 64'(mon_e.id));
                    check_val("pop_payload", m_pl, mon_e.pl);
                end
            end
            prev_stall = m_valid && !out_ready;
            prev_id    = m_id;
            prev_pl    = m_pl;
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; mon_sel = 1'b0;
        rst = 1'b0; issue_valid = 1'b0; issue_id = '0; issue_payload = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check_val("rst_count", 64'(count_a), 64'd0);
        check_val("rst_out_valid", 64'(out_valid_a), 64'd0);
        check_val("rst_issue_ready", 64'(issue_ready_a), 64'd0);
        check_val("rst_dbg_valid", 64'(dbg_valid_a), 64'd0);
        check_val("rst_out_id", 64'(out_id_a), 64'd0);
        check_val("rst_out_payload", out_payload_a, 64'd0);
        check_val("rst_dbg_ids", 64'(dbg_ids_a), 64'd0);
        rst = 1'b1;
        #1 check_val("ready_after_rst", 64'(issue_ready_a), 64'd1);

        // Fill and drain
        for (int k = 1; k <= 4; k++) begin
            drive_issue(4'(k), 1'b1);
            tick();
        end
        issue_valid = 1'b0;
        check_val("fill_count", 64'(count_a), 64'd4);
        check_val("fill_ready", 64'(issue_ready_a), 64'd0);
        check_val("fill_out_valid", 64'(out_valid_a), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            set_commit(4'(k), 1'b0);
            tick();
            check_val("drain_valid", 64'(out_valid_a), 64'd1);
            check_val("drain_id", 64'(out_id_a), 64'(k));
        end
        commit_valid = 1'b0;
        tick();
        check_val("drain_count", 64'(count_a), 64'd0);

        // Out-of-order commit
        drive_issue(4'd3, 1'b1); tick();
        drive_issue(4'd5, 1'b1); tick();
        drive_issue(4'd7, 1'b1); tick();
        issue_valid = 1'b0;
        set_commit(4'd7, 1'b0); tick();
        check_val("ooo_wait7", 64'(out_valid_a), 64'd0);
        set_commit(4'd5, 1'b0); tick();
        check_val("ooo_wait5", 64'(out_valid_a), 64'd0);
        set_commit(4'd3, 1'b0); tick();
        commit_valid = 1'b0;
        check_val("ooo_id3", 64'(out_id_a), 64'd3);
        tick(); check_val("ooo_id5", 64'(out_id_a), 64'd5);
        tick(); check_val("ooo_id7", 64'(out_id_a), 64'd7);
        tick(); check_val("ooo_count", 64'(count_a), 64'd0);

        // Kill at head
        drive_issue(4'd2, 1'b0); tick();
        drive_issue(4'd6, 1'b1); tick();
        issue_valid = 1'b0;
        set_commit(4'd2, 1'b1); tick();
        check_val("kill_bubble", 64'(out_valid_a), 64'd0);
        check_val("kill_count2", 64'(count_a), 64'd2);
        set_commit(4'd6, 1'b0); tick();
        commit_valid = 1'b0;
        check_val("kill_valid6", 64'(out_valid_a), 64'd1);
        check_val("kill_id6", 64'(out_id_a), 64'd6);
        check_val("kill_count1", 64'(count_a), 64'd1);
        tick(); check_val("kill_count0", 64'(count_a), 64'd0);

        // Duplicate ids and same-cycle bypass
        drive_issue(4'd4, 1'b1); tick();
        drive_issue(4'd4, 1'b1); tick();
        issue_valid = 1'b0;
        set_commit(4'd4, 1'b0); tick();
        commit_valid = 1'b0;
        check_val("dup_valid", 64'(out_valid_a), 64'd1);
        check_val("dup_count2", 64'(count_a), 64'd2);
        tick();
        check_val("dup_young_pending", 64'(out_valid_a), 64'd0);
        check_val("dup_count1", 64'(count_a), 64'd1);
        set_commit(4'd4, 1'b0); tick();
        commit_valid = 1'b0;
        check_val("dup_young_valid", 64'(out_valid_a), 64'd1);
        tick();
        drive_issue(4'd9, 1'b1); set_commit(4'd9, 1'b0); tick();
        issue_valid = 1'b0; commit_valid = 1'b0;
        check_val("bypass_valid", 64'(out_valid_a), 64'd1);
        check_val("bypass_id", 64'(out_id_a), 64'd9);
        tick();
        drive_issue(4'd11, 1'b0); set_commit(4'd11, 1'b1); tick();
        issue_valid = 1'b0; commit_valid = 1'b0;
        check_val("bypass_kill_valid", 64'(out_valid_a), 64'd0);
        check_val("bypass_kill_count", 64'(count_a), 64'd1);
        tick(); check_val("bypass_kill_drop", 64'(count_a), 64'd0);

        // Wrap and stall on the depth-3 instance
        mon_sel = 1'b1; issued = 0; cyc = 0;
        while ((issued < 10 || count_b != 2'd0) && cyc < 200) begin
            out_ready = ((cyc % 3) != 1);
            if (issued < 10 && issue_ready_b) begin
                drive_issue(4'(issued + 1), 1'b1);
                set_commit(4'(issued + 1), 1'b0);
                issued++;
            end else begin
                issue_valid = 1'b0; commit_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        issue_valid = 1'b0; commit_valid = 1'b0; out_ready = 1'b1;
        check_val("wrap_issued", 64'(issued), 64'd10);
        check_val("wrap_count", 64'(count_b), 64'd0);
        check_val("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with a same-cycle issue
        rst = 1'b0; mon_sel = 1'b0; tick(); rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            drive_issue(4'(k), 1'b0);
            tick();
        end
        issue_valid = 1'b0;
        check_val("pre_flush_count", 64'(count_a), 64'd3);
        flush = 1'b1; drive_issue(4'd8, 1'b0);
        #1 check_val("flush_ready", 64'(issue_ready_a), 64'd0);
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        check_val("flush_count", 64'(count_a), 64'd0);
        check_val("flush_dbg_valid", 64'(dbg_valid_a), 64'd0);
        set_commit(4'd8, 1'b0); tick();
        commit_valid = 1'b0;
        check_val("flush_absent", 64'(out_valid_a), 64'd0);

        // Reset mid-drain
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_issue(4'(k), k == 1);
            set_commit(4'(k), 1'b0);
            tick();
        end
        issue_valid = 1'b0; commit_valid = 1'b0;
        check_val("md_count3", 64'(count_a), 64'd3);
        check_val("md_valid", 64'(out_valid_a), 64'd1);
        out_ready = 1'b1; tick();
        check_val("md_count2", 64'(count_a), 64'd2);
        rst = 1'b0; tick();
        check_val("md_rst_valid", 64'(out_valid_a), 64'd0);
        check_val("md_rst_count", 64'(count_a), 64'd0);
        check_val("md_rst_ready", 64'(issue_ready_a), 64'd0);
        rst = 1'b1; tick();
        check_val("md_after_valid", 64'(out_valid_a), 64'd0);
        check_val("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
